// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle for pipe_stage_buf: upstream {pc, data} channel and downstream head channel.
// The slave modport is the stage itself, and the master modport is the surrounding pipeline.
interface pipe_stage_buf_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_pc, in_data, out_ready,
    output in_ready, out_valid, out_pc, out_data
  );

  modport master (
    output in_valid, in_pc, in_data, out_ready,
    input  in_ready, out_valid, out_pc, out_data
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Parametrised pipeline stage register: a 2-entry skid buffer that carries {pc, data}
// with a valid/ready handshake. in_ready is registered, and flush squashes the stage to a NOP bubble.
// Optional feature macro PIPE_STAGE_PERF_EN adds a 32-bit stall_cnt output.
module pipe_stage_buf #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       PC_W     = 32,
  parameter logic [PC_W-1:0]   RESET_PC = 32'h80000000,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
`ifdef PIPE_STAGE_PERF_EN
  output logic [31:0]           stall_cnt,
`endif
  pipe_stage_buf_if.slave       bus
);

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_TWO   = 2'd2;

  logic [1:0]        count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  // The head register H is out_pc_q / out_data_q. out_data_q is NOP_WORD whenever the stage is empty.
  logic [PC_W-1:0]   out_pc_q, out_pc_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [DATA_W-1:0] head_data;
  logic              push, pop;

  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid_q & bus.out_ready;

  // Next-state for the occupancy count, the head register and the skid register.
  always_comb begin
    count_d     = count_q;
    out_pc_d    = out_pc_q;
    head_data   = out_data_q;
    skid_pc_d   = skid_pc_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      // out_pc holds its value. A push in this cycle is dropped, and a pop completes by itself.
      count_d = CNT_EMPTY;
    end else begin
      unique case (count_q)
        CNT_EMPTY: begin
          if (push) begin
            count_d   = CNT_ONE;
            out_pc_d  = bus.in_pc;
            head_data = bus.in_data;
          end
        end
        CNT_ONE: begin
          if (push && pop) begin
            out_pc_d  = bus.in_pc;
            head_data = bus.in_data;
          end else if (push) begin
            count_d     = CNT_TWO;
            skid_pc_d   = bus.in_pc;
            skid_data_d = bus.in_data;
          end else if (pop) begin
            count_d = CNT_EMPTY;
          end
        end
        CNT_TWO: begin
          if (pop) begin
            count_d   = CNT_ONE;
            out_pc_d  = skid_pc_q;
            head_data = skid_data_q;
          end
        end
        default: count_d = CNT_EMPTY;
      endcase
    end
    out_valid_d = (count_d != CNT_EMPTY);
    in_ready_d  = (count_d != CNT_TWO);
    out_data_d  = out_valid_d ? head_data : NOP_WORD;
  end

  // State and registered outputs. Async reset returns the stage to the empty bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= CNT_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_pc_q    <= RESET_PC;
      out_data_q  <= NOP_WORD;
      skid_pc_q   <= '0;
      skid_data_q <= '0;
    end else begin
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      out_pc_q    <= out_pc_d;
      out_data_q  <= out_data_d;
      skid_pc_q   <= skid_pc_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.out_data  = out_data_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_q;

  // Count the cycles where the head is valid and held back. Only reset clears the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (out_valid_q && !bus.out_ready) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
